// File: rtl/fetch_pc_gen_if.sv
// fetch_pc_gen_if: fetch-stage bundle linking the next-PC generator to BTB, imem, decode and execute
interface fetch_pc_gen_if #(parameter int AWIDTH = 32);
    logic              btb_valid;
    logic [AWIDTH-1:0] btb_target;
    logic              d_ready;
    logic              x_valid;
    logic              x_is_br;
    logic              x_taken;
    logic [AWIDTH-1:0] x_pc;
    logic [AWIDTH-1:0] x_target;
    logic              x_pred_taken;
    logic [AWIDTH-1:0] x_pred_target;
    logic [AWIDTH-1:0] pc_f;
    logic              f_valid;
    logic              pred_taken_f;
    logic [AWIDTH-1:0] pred_target_f;
    logic              br_x;
    logic              flush;
    logic [15:0]       mispred_cnt;
    modport master (
        input  btb_valid, btb_target, d_ready, x_valid, x_is_br, x_taken, x_pc, x_target,
               x_pred_taken, x_pred_target,
        output pc_f, f_valid, pred_taken_f, pred_target_f, br_x, flush, mispred_cnt
    );
    modport slave (
        output btb_valid, btb_target, d_ready, x_valid, x_is_br, x_taken, x_pc, x_target,
               x_pred_taken, x_pred_target,
        input  pc_f, f_valid, pred_taken_f, pred_target_f, br_x, flush, mispred_cnt
    );
endinterface

// File: rtl/fetch_pc_gen.sv
// fetch_pc_gen: fetch PC register with BTB + 2-bit direction prediction and mispredict recovery
module fetch_pc_gen #(
    parameter int                AWIDTH   = 32,
    parameter logic [AWIDTH-1:0] RESET_PC = '0
) (
    input  logic           clk,
    input  logic           rst,
    fetch_pc_gen_if.master bus
);
    typedef enum logic [1:0] {BOOT, RUN, RECOVER} state_t;
    state_t            r_state, w_state_nxt;
    logic [AWIDTH-1:0] r_pc;
    logic [1:0]        r_ctr [4];
    logic [15:0]       r_cnt;
    logic              w_br, w_mis, w_pred_taken;
    logic [AWIDTH-1:0] w_x_pc4, w_actual, w_pred, w_pred_target;
    logic [1:0]        w_ctr_x, w_ctr_nxt;
    assign w_br          = bus.x_valid & bus.x_is_br;
    assign w_x_pc4       = bus.x_pc + AWIDTH'(4);
    assign w_actual      = bus.x_taken ? bus.x_target : w_x_pc4;
    assign w_pred        = bus.x_pred_taken ? bus.x_pred_target : w_x_pc4;
    // execute can only redirect while fetching; BOOT/RECOVER never carry a live branch
    assign w_mis         = w_br & (w_actual != w_pred) & (r_state == RUN);
    assign w_pred_taken  = bus.btb_valid & r_ctr[r_pc[3:2]][1];
    assign w_pred_target = w_pred_taken ? bus.btb_target : r_pc + AWIDTH'(4);
    assign w_ctr_x       = r_ctr[bus.x_pc[3:2]];
    assign w_ctr_nxt     = bus.x_taken ? ((w_ctr_x == 2'b11) ? w_ctr_x : w_ctr_x + 2'b01)
                                       : ((w_ctr_x == 2'b00) ? w_ctr_x : w_ctr_x - 2'b01);
    always_ff @(posedge clk) r_state <= rst ? BOOT : w_state_nxt;
    always_comb begin
        w_state_nxt = (r_state == RUN && w_mis) ? RECOVER : RUN;
    end
    always_comb begin
        bus.pc_f          = r_pc;
        bus.f_valid       = r_state == RUN;
        bus.pred_taken_f  = w_pred_taken;
        bus.pred_target_f = w_pred_target;
        bus.br_x          = w_br;
        bus.flush         = w_mis;
        bus.mispred_cnt   = r_cnt;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc  <= RESET_PC;
            r_cnt <= '0;
            r_ctr <= '{default: 2'b01};
        end else begin
            if (w_mis) r_pc <= w_actual;
            else if (r_state == RUN && bus.d_ready) r_pc <= w_pred_target;
            if (w_br) r_ctr[bus.x_pc[3:2]] <= w_ctr_nxt;
            if (w_mis && r_cnt != 16'hFFFF) r_cnt <= r_cnt + 16'd1;
        end
    end
endmodule

// File: doc/fetch_pc_gen.md
# fetch_pc_gen

Fetch-stage next-PC generator, directly upstream of the branch target buffer. Holds the fetch PC, drives it to the BTB and instruction memory, and combines the BTB hit/target with a 4-entry 2-bit direction table to pick the next PC. Resolves branches reported by execute, detects mispredictions, and redirects and flushes the front end. Presents fetched PCs to decode through a valid/ready handshake.

## Interface
- AWIDTH, 32, address width
- RESET_PC, 32'h0000_0000, first fetch address after reset
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- btb_valid  in  1  BTB hit for current pc_f (BTB Target_valid)
- btb_target  in  AWIDTH  BTB target for pc_f (BTB BrTarget)
- d_ready  in  1  decode accepts the current fetch
- x_valid  in  1  execute holds a valid instruction
- x_is_br  in  1  execute instruction is a branch or jump
- x_taken  in  1  resolved direction
- x_pc  in  AWIDTH  PC of execute instruction
- x_target  in  AWIDTH  resolved target (alu_out)
- x_pred_taken  in  1  prediction carried down with the instruction
- x_pred_target  in  AWIDTH  predicted target carried down
- pc_f  out  AWIDTH  fetch PC (to BTB PC_f and imem)
- f_valid  out  1  pc_f is a valid fetch for decode
- pred_taken_f  out  1  prediction for pc_f
- pred_target_f  out  AWIDTH  btb_target when pred_taken_f, else pc_f+4
- br_x  out  1  BTB write enable (= x_valid & x_is_br)
- flush  out  1  kill F/D and D/X instructions
- mispred_cnt  out  16  saturating mispredict count

## Operation
- Direction table: 4 × 2-bit counters indexed by PC[3:2]. Reset value 2'b01 (weakly not-taken).
- pred_taken_f = btb_valid & ctr[pc_f[3:2]][1]. Combinational from the registered pc_f.
- Update on br_x at index x_pc[3:2]:
  - x_taken=1: increment, saturating at 2'b11.
  - x_taken=0: decrement, saturating at 2'b00.
- Mispredict = br_x & (actual_next != pred_next).
  - actual_next = x_taken ? x_target : x_pc+4.
  - pred_next = x_pred_taken ? x_pred_target : x_pc+4.
  - All additions are modulo 2^AWIDTH; wrap-around is not flagged.
- flush = mispredict. It is combinational, in the same cycle as the execute instruction.
- FSM states: BOOT, RUN, RECOVER.
  - BOOT: entered while rst=1. On the first non-reset cycle, f_valid=0 and pc_f=RESET_PC. Goes to RUN next cycle.
  - RUN: f_valid=1.
    - mispredict: pc_f <= actual_next; go to RECOVER.
    - else if d_ready: pc_f <= pred_target_f.
    - else: pc_f holds and pred outputs stay stable.
  - RECOVER: f_valid=0 for exactly one cycle. This lets the BTB and counter writes land before the corrected PC is looked up. pc_f holds; go to RUN.
- Priority: rst > mispredict > stall (d_ready=0) > advance.
- A mispredict reported in RECOVER or BOOT is ignored. Upstream guarantees none occurs, because a flush empties the D/X stage.
- mispred_cnt increments on each mispredict and saturates at 16'hFFFF.

## Timing
- Reset values:
  - pc_f = RESET_PC
  - f_valid = 0
  - state = BOOT
  - all counters = 2'b01
  - mispred_cnt = 0
  - flush = 0 and br_x = 0, since x_valid is expected low during reset
- Latency: 1 cycle from pc_f to the next pc_f on a predicted path. Mispredict penalty is 1 cycle of redirect plus 1 RECOVER bubble.
- Handshake: transfer occurs when f_valid & d_ready. With f_valid=1 and d_ready=0, pc_f, pred_taken_f and pred_target_f are held.
- Counter update and the state/PC update occur on the same clock edge. A read of the same index in that cycle sees the old value.
- rst asserted mid-operation: all state returns to reset values at the next edge, regardless of stall or mispredict.

## Test plan
- Reset then run: rst for 2 cycles, d_ready=1, btb_valid=0 -> one cycle with f_valid=0, then pc_f = 0x0, 0x4, 0x8, 0xC.
- BTB hit with counter 2'b11: counter at index 1 trained with two taken resolutions at x_pc=0x4; pc_f=0x4, btb_valid=1, btb_target=0x40 -> pred_taken_f=1, next pc_f=0x40.
- Stall: d_ready=0 for 3 cycles at pc_f=0x8 -> pc_f stays 0x8 and f_valid stays 1. pc_f becomes 0xC the cycle after d_ready returns to 1.
- Mispredict: x_pc=0x10, x_taken=1, x_target=0x80, x_pred_taken=0 ->
  - flush=1 in that cycle;
  - next cycle pc_f=0x80 with f_valid=0;
  - following cycle f_valid=1;
  - mispred_cnt=1;
  - counter at index 0 becomes 2'b10.
- Correct prediction: x_pred_taken=1, x_pred_target=0x80, x_taken=1, x_target=0x80 -> flush=0, br_x=1, no redirect.
- Saturation and priority:
  - 4 decrements on one index -> counter holds 2'b00.
  - mispredict together with d_ready=0 -> redirect still taken.
  - rst during RECOVER -> pc_f=RESET_PC on the next edge.
